// File: rtl/fir_dlms_gen.sv
// fir_dlms_gen: delayed-LMS adaptive FIR filter.
//   L taps, W1-bit signed fractional data and coefficients (FRAC fractional
//   bits), D-stage pipelined multipliers in both the filter and the update
//   path. The step size is mu = 2^-MU_SH.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; clears all state and in-flight samples
//   x_in       filter input sample (signed, W1)
//   d_in       desired sample (signed, W1), aligned with x_in
//   valid_in   sample strobe; the whole datapath advances only when 1
//   adapt_en   1 = coefficients update on valid steps, 0 = frozen
//   y_out      registered filter output (W2)
//   e_out      registered error d - (y >>> FRAC) (W2)
//   valid_out  one-cycle pulse per step once the pipeline has filled
//   f_out      packed coefficients, f[k] at bits [k*W1 +: W1]
//   sat_flag   sticky; set when any coefficient update clipped
module fir_dlms_gen #(
  parameter int W1    = 8,
  parameter int L     = 4,
  parameter int D     = 3,
  parameter int MU_SH = 2,
  parameter int FRAC  = W1 - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [W1-1:0] x_in,
  input  logic signed [W1-1:0] d_in,
  input  logic                 valid_in,
  input  logic                 adapt_en,
  output logic signed [2*W1-1:0] y_out,
  output logic signed [2*W1-1:0] e_out,
  output logic                 valid_out,
  output logic [L*W1-1:0]      f_out,
  output logic                 sat_flag
);

  localparam int W2 = 2 * W1;
  localparam int NX = L + D;              // x[0 .. L-1+D]
  localparam int CW = $clog2(D + 2);
  localparam logic [CW-1:0] FILL_MAX = CW'(D + 1);
  localparam logic signed [W2-1:0] EMU_MAX = W2'((2 ** (W1 - 1)) - 1);
  localparam logic signed [W2-1:0] EMU_MIN = ~EMU_MAX;

  logic signed [W1-1:0] x_dl [NX];
  logic signed [W1-1:0] d_dl [D+1];
  logic signed [W1-1:0] f    [L];
  logic signed [W2-1:0] pf   [D][L];      // filter product pipeline
  logic signed [W2-1:0] pu   [D][L];      // update product pipeline
  logic [CW-1:0]        fill_cnt;

  logic signed [W2-1:0] y_sum;
  logic signed [W2-1:0] e_val;
  logic signed [W2-1:0] e_sh;
  logic signed [W1-1:0] emu;
  logic signed [W1:0]   f_sum  [L];
  logic signed [W1-1:0] f_next [L];
  logic [L-1:0]         clip;

  // NOTE: combinational accumulation uses blocking '=' so each loop
  // iteration sees the previous partial sum; registers below use '<='.
  always_comb begin
    y_sum = '0;
    for (int k = 0; k < L; k++) y_sum = y_sum + pf[D-1][k];
  end

  assign e_val = W2'(d_dl[D]) - (y_sum >>> FRAC);
  assign e_sh  = e_val >>> MU_SH;

  // NOTE: every combinational output is assigned on every path (default
  // first) so no latch is inferred.
  always_comb begin
    emu = e_sh[W1-1:0];
    if (e_sh > EMU_MAX)      emu = EMU_MAX[W1-1:0];
    else if (e_sh < EMU_MIN) emu = EMU_MIN[W1-1:0];
  end

  // Coefficient update in W1+1 bits: f + (u >>> FRAC) always fits there, so
  // a mismatch of the top two bits means the W1 result must clip.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      f_sum[k]  = (W1+1)'(f[k]) + (W1+1)'(pu[D-1][k] >>> FRAC);
      clip[k]   = f_sum[k][W1] ^ f_sum[k][W1-1];
      f_next[k] = f_sum[k][W1-1:0];
      if (clip[k])
        f_next[k] = f_sum[k][W1] ? {1'b1, {(W1-1){1'b0}}} : {1'b0, {(W1-1){1'b1}}};
    end
  end

  always_comb begin
    f_out = '0;
    for (int k = 0; k < L; k++) f_out[k*W1 +: W1] = f[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the delay lines and product pipelines are reset as well, not
      // just control state: a reset must discard every in-flight sample so
      // that stale products never reach y/e or the coefficient update.
      for (int i = 0; i < NX; i++) x_dl[i] <= '0;
      for (int i = 0; i <= D; i++) d_dl[i] <= '0;
      for (int k = 0; k < L; k++) begin
        f[k] <= '0;
        for (int s = 0; s < D; s++) begin
          pf[s][k] <= '0;
          pu[s][k] <= '0;
        end
      end
      y_out     <= '0;
      e_out     <= '0;
      fill_cnt  <= '0;
      valid_out <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (valid_in) begin
      x_dl[0] <= x_in;
      for (int i = 1; i < NX; i++) x_dl[i] <= x_dl[i-1];
      d_dl[0] <= d_in;
      for (int i = 1; i <= D; i++) d_dl[i] <= d_dl[i-1];

      for (int k = 0; k < L; k++) begin
        pf[0][k] <= W2'(x_dl[k]) * W2'(f[k]);
        pu[0][k] <= W2'(x_dl[k+D]) * W2'(emu);
        for (int s = 1; s < D; s++) begin
          pf[s][k] <= pf[s-1][k];
          pu[s][k] <= pu[s-1][k];
        end
      end

      y_out <= y_sum;
      e_out <= e_val;

      if (adapt_en) begin
        for (int k = 0; k < L; k++) f[k] <= f_next[k];
        if (|clip) sat_flag <= 1'b1;
      end

      // The count before this step decides the strobe: the first result
      // carrying a real sample lands on step D+2 after reset.
      if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
      valid_out <= (fill_cnt == FILL_MAX);
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_dlms_gen.sv
// Self-checking bench for fir_dlms_gen: directed vectors, with a step-indexed
// reference model (history arrays indexed by step number) for the default
// instance and hand-derived expectations for an L=1, MU_SH=0 instance.
module tb_fir_dlms_gen;

  localparam int W1   = 8;
  localparam int L_M  = 4;
  localparam int D_M  = 3;
  localparam int MAXS = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic                 reset;
  logic signed [7:0]    x_in, d_in;
  logic                 valid_in, adapt_en;
  logic signed [15:0]   y_out, e_out;
  logic                 valid_out;
  logic [31:0]          f_out;
  logic                 sat_flag;

  // L=1, MU_SH=0 instance
  logic                 reset2;
  logic signed [7:0]    x2, d2;
  logic                 v2, a2;
  logic signed [15:0]   y2, e2;
  logic                 vo2;
  logic [7:0]           f2;
  logic                 sat2;

  fir_dlms_gen dut (
    .clk(clk), .reset(reset), .x_in(x_in), .d_in(d_in),
    .valid_in(valid_in), .adapt_en(adapt_en), .y_out(y_out), .e_out(e_out),
    .valid_out(valid_out), .f_out(f_out), .sat_flag(sat_flag)
  );

  fir_dlms_gen #(.L(1), .MU_SH(0)) dut2 (
    .clk(clk), .reset(reset2), .x_in(x2), .d_in(d2),
    .valid_in(v2), .adapt_en(a2), .y_out(y2), .e_out(e2),
    .valid_out(vo2), .f_out(f2), .sat_flag(sat2)
  );

  int checks = 0;
  int errors = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // ---------------- reference model (default instance) ----------------
  int xi  [MAXS];
  int di  [MAXS];
  int fh  [MAXS][L_M];
  int yh  [MAXS];
  int eh  [MAXS];
  int emh [MAXS];
  bit sat_m;
  int s_cnt;

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int xv(input int idx);  return (idx >= 1) ? xi[idx]  : 0; endfunction
  function automatic int dv(input int idx);  return (idx >= 1) ? di[idx]  : 0; endfunction
  function automatic int emv(input int idx); return (idx >= 1) ? emh[idx] : 0; endfunction
  function automatic int fv(input int idx, input int k); return (idx >= 1) ? fh[idx][k] : 0; endfunction

  task automatic model_reset();
    s_cnt = 0;
    sat_m = 1'b0;
    for (int k = 0; k < L_M; k++) fh[0][k] = 0;
    yh[0] = 0; eh[0] = 0; emh[0] = 0;
  endtask

  task automatic model_step(input int x, input int d, input bit a);
    int s, u, t, acc, e;
    bit clip_any;
    s_cnt++;
    s = s_cnt;
    xi[s] = x;
    di[s] = d;
    clip_any = 1'b0;
    for (int k = 0; k < L_M; k++) begin
      if (a) begin
        u = xv(s - 1 - 2*D_M - k) * emv(s - 1 - D_M);
        t = fv(s - 1, k) + (u >>> 7);
        if (t > 127 || t < -128) clip_any = 1'b1;
        fh[s][k] = sat8(t);
      end else begin
        fh[s][k] = fh[s-1][k];
      end
    end
    if (clip_any) sat_m = 1'b1;
    acc = 0;
    for (int k = 0; k < L_M; k++) acc += xv(s - D_M - k) * fv(s - D_M, k);
    yh[s]  = wrap16(acc);
    e      = wrap16(dv(s - D_M) - (yh[s] >>> 7));
    eh[s]  = e;
    emh[s] = sat8(e >>> 2);
  endtask

  task automatic compare_outputs(input bit stepped);
    logic signed [15:0] ye, ee;
    logic [31:0] fe;
    ye = (s_cnt >= 1) ? 16'(yh[s_cnt-1]) : 16'sd0;
    ee = (s_cnt >= 1) ? 16'(eh[s_cnt-1]) : 16'sd0;
    for (int k = 0; k < L_M; k++) fe[k*8 +: 8] = 8'(fh[s_cnt][k]);
    check("y", y_out, ye);
    check("e", e_out, ee);
    check("f", f_out, fe);
    check("valid", valid_out, stepped && (s_cnt >= D_M + 2));
    check("sat", sat_flag, sat_m);
  endtask

  task automatic tick(input int x, input int d, input bit v, input bit a);
    x_in = 8'(x); d_in = 8'(d); valid_in = v; adapt_en = a;
    @(posedge clk); #1;
    if (v) model_step(x, d, a);
    compare_outputs(v);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      x_in = 8'($urandom); d_in = 8'($urandom);
      valid_in = 1'b1; adapt_en = 1'($urandom);
      @(posedge clk); #1;
    end
    model_reset();
    check("rst_y", y_out, 64'd0);
    check("rst_e", e_out, 64'd0);
    check("rst_f", f_out, 64'd0);
    check("rst_valid", valid_out, 64'd0);
    check("rst_sat", sat_flag, 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid;
    int xt [10];
    int dt [10];
    int min_f;

    reset = 1'b1; x_in = '0; d_in = '0; valid_in = 1'b0; adapt_en = 1'b0;
    reset2 = 1'b1; x2 = '0; d2 = '0; v2 = 1'b0; a2 = 1'b0;
    model_reset();

    // 1: reset with random inputs
    phase = "reset";
    do_reset(2);

    // 2: frozen coefficients, constant input
    phase = "frozen";
    first_valid = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(64, 32, 1'b1, 1'b0);
      if (valid_out && first_valid < 0) first_valid = i;
    end
    check("first_valid", 64'(first_valid), 64'd5);
    check("y_frozen", y_out, 64'd0);
    check("e_frozen", e_out, 64'd32);

    // 3/4: adaptation, with a 5-cycle valid gap mid-run
    phase = "adapt";
    do_reset(1);
    for (int i = 1; i <= 220; i++) begin
      if (i == 120) begin
        phase = "gap";
        for (int g = 0; g < 5; g++) tick(99, -77, 1'b0, 1'b1);
        phase = "adapt";
      end
      tick(64, 32, 1'b1, 1'b1);
    end

    // 6: one-cycle reset mid-run while valid_in=1
    phase = "midrst";
    do_reset(1);
    first_valid = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(64, 32, 1'b1, 1'b1);
      if (valid_out && first_valid < 0) first_valid = i;
    end
    check("first_valid", 64'(first_valid), 64'd5);

    // varied samples, adapt_en toggling every 7 steps, occasional gaps
    phase = "table";
    xt = '{64, -32, 16, 100, -100, 8, -128, 127, 0, 45};
    dt = '{32, -20, 50, -90, 10, 127, -128, 0, 60, -5};
    for (int i = 0; i < 80; i++) begin
      if (i % 13 == 12) tick(1, 1, 1'b0, 1'b1);
      tick(xt[i % 10], dt[(i * 3) % 10], 1'b1, ((i / 7) % 2) == 0);
    end
    valid_in = 1'b0;

    // 5: L=1, MU_SH=0, full-scale input: f[0] must clamp at 127
    phase = "clamp";
    @(posedge clk); #1;
    check("rst2_f", f2, 64'd0);
    check("rst2_sat", sat2, 64'd0);
    check("rst2_valid", vo2, 64'd0);
    reset2 = 1'b0;
    x2 = 8'sd127; d2 = 8'sd127; v2 = 1'b1; a2 = 1'b1;
    min_f = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 8) check("f2_first", f2, 64'd126);
      if ($signed(f2) < min_f) min_f = $signed(f2);
    end
    check("f2_nonneg", 64'(min_f >= 0), 64'd1);
    check("f2_clamp", f2, 64'd127);
    check("sat2_set", sat2, 64'd1);
    a2 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("f2_frozen", f2, 64'd127);
    check("sat2_sticky", sat2, 64'd1);
    v2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_dlms_gen.md
Name: fir_dlms_gen

Overview:
Parametrised delayed-LMS adaptive FIR filter with L taps, W1-bit signed fractional data and coefficients, and D-stage pipelined multipliers in both the filter and update paths.
It generalises the fixed 2-tap DLMS block with these additions:
- configurable tap count, width, pipeline depth and step size
- sample-valid clock enable
- adaptation enable/freeze
- saturating coefficient update with sticky overflow flag
- output-valid strobe after pipeline fill
It sits in the adaptive-filter datapath between the sample source and the error/monitor logic.

Parameters:
W1, 8, data/coefficient width (signed, FRAC fractional bits)
L, 4, number of taps (1..16)
D, 3, multiplier pipeline stages (>=1), applied to both multiplier banks
MU_SH, 2, step size mu = 2^-MU_SH (arithmetic right shift of e)
FRAC, W1-1, fractional bits of x/f; used for product rescaling
(derived, not overridable) W2 = 2*W1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
x_in  in  W1  filter input sample, signed
d_in  in  W1  desired sample, signed, aligned with x_in
valid_in  in  1  sample strobe; whole datapath advances only when 1
adapt_en  in  1  1 = coefficients update on valid steps; 0 = frozen
y_out  out  W2  filter output, registered
e_out  out  W2  error d - (y>>>FRAC), registered
valid_out  out  1  y_out/e_out hold a valid result this cycle
f_out  out  L*W1  packed coefficients, f[k] at bits [k*W1 +: W1]
sat_flag  out  1  sticky; set when any coefficient update saturated

Behaviour:
- Reset (synchronous, clk edge with reset=1): x and d delay lines, both multiplier pipelines, all f[k], y_out, e_out, fill counter, valid_out and sat_flag go to 0. Reset overrides valid_in. Reset mid-operation discards all in-flight samples.
- Step: a clk edge with valid_in=1 and reset=0. With valid_in=0, every register holds, valid_out=0 and adapt_en is ignored.
- x delay line: x[0] <= x_in; x[k] <= x[k-1] for k = 1..L-1+D. d delay line: d[0] <= d_in; d[k] <= d[k-1] for k = 1..D.
- Filter products: p[k] = x[k]*f[k], full W2 signed, D pipeline stages, each stage advancing on steps only.
- Output: y = sum of p[k], computed in W2 with two's-complement wrap.
- Error: e = d[D] - (y >>> FRAC), computed in W2.
- Scaled error: emu = e >>> MU_SH, saturated to the W1 signed range [-2^(W1-1), 2^(W1-1)-1].
- Update products: u[k] = x[k+D]*emu, full W2 signed, D pipeline stages gated by steps.
- Coefficient update, on a step with adapt_en=1: f[k] <= sat_W1(f[k] + (u[k] >>> FRAC)), sum computed in W1+1 bits. If any tap clips, sat_flag <= 1; sat_flag clears only on reset.
- Frozen: on a step with adapt_en=0, f holds and the filter path keeps running.
- y_out and e_out are registered on each step.
- Fill counter counts steps and saturates at D+1. valid_out = 1 on the cycle after a step, once the counter has reached D+1; otherwise 0. valid_out is a single-cycle pulse per step.
- Latency: x_in on step n affects y_out at step n+D+1 (the registered output).
- Simultaneous reset and valid_in=1: reset wins. An adapt_en toggle takes effect on the same step.

Test Plan:
1. Assert reset for 2 cycles with random inputs -> y_out=e_out=0, f_out=0, valid_out=0, sat_flag=0.
2. Defaults, adapt_en=0, valid_in=1 every cycle, x_in=64, d_in=32 -> first valid_out pulse 5 cycles after the first step; y_out=0, e_out=32, f_out stays 0.
3. Defaults, adapt_en=1, x_in=64, d_in=32 for 300 steps -> sum of f[k] within 64±4; |e_out| <= 2; sat_flag=0.
4. As scenario 3, with valid_in low for 5 cycles mid-run -> f_out, y_out, e_out unchanged during the gap; valid_out=0 during the gap; run resumes identically to an ungapped run with the gap removed.
5. L=1, MU_SH=0, x_in=127, d_in=127, adapt_en=1 -> f[0] climbs and clamps at 127 (no wrap to negative); sat_flag=1 and stays 1 after adapt_en=0.
6. Reset asserted for 1 cycle mid-run in scenario 3 -> next cycle f_out=0, valid_out=0; the next valid_out appears only after D+1 new steps.
